// File: rtl/pc_next_unit.sv
// pc_next_unit: next-PC select, fetch handshake, misaligned-target trap and retire counter
module pc_next_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_result,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        commit,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        misalign_trap,
    output logic [31:0] trap_pc,
    output logic [31:0] retired_count
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, TRAP} state_t;
    state_t state;
    logic [31:0] target;
    assign pc_plus4      = pc + 32'd4;
    assign imem_addr     = pc;
    assign imem_req      = state == FETCH;
    assign instr_valid   = state == EXEC;
    assign misalign_trap = state == TRAP;
    // JALR outranks JAL, which outranks a taken branch
    always_comb begin
        target = is_jalr                           ? (rs1_data + imm) & ~32'h1 :
                 (is_jal || (is_branch && branch_result)) ? pc + imm :
                 pc_plus4;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_VECTOR;
            trap_pc       <= '0;
            retired_count <= '0;
        end else begin
            case (state)
                IDLE:  state <= FETCH;
                FETCH: state <= imem_ready ? EXEC : FETCH;
                EXEC:
                    if (commit) begin
                        if (target[1:0] != 2'b00) begin
                            state   <= TRAP;
                            trap_pc <= pc;
                        end else begin
                            state         <= FETCH;
                            pc            <= target;
                            retired_count <= retired_count + 32'd1;
                        end
                    end
                TRAP: begin
                    state <= FETCH;
                    pc    <= TRAP_VECTOR;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed scoreboard bench; expected fetch addresses are queued at each commit
module tb_pc_next_unit;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    logic clk = 0, rst = 1, branch_result = 0, is_branch = 0, is_jal = 0, is_jalr = 0;
    logic commit = 0, imem_ready = 0;
    logic [31:0] imm = 0, rs1_data = 0;
    logic imem_req, instr_valid, misalign_trap;
    logic [31:0] imem_addr, pc, pc_plus4, trap_pc, retired_count;
    int checks = 0, failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_ret = 0, exp_trap_pc = 0, cur_pc = 0, a;

    pc_next_unit dut (
        .clk(clk), .rst(rst), .branch_result(branch_result), .is_branch(is_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .imm(imm), .rs1_data(rs1_data),
        .commit(commit), .imem_ready(imem_ready), .imem_req(imem_req),
        .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
        .misalign_trap(misalign_trap), .trap_pc(trap_pc), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req;
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("fetch_req", imem_req, 1);
    endtask

    task automatic fetch;
        wait_req();
        a = exp_q.size() != 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
        cur_pc = a;
        chk("fetch_addr", imem_addr, a);
        chk("fetch_pc", pc, a);
        imem_ready = 1;
        tick();
        imem_ready = 0;
        chk("exec_valid", instr_valid, 1);
        chk("exec_no_req", imem_req, 0);
    endtask

    task automatic exec(input logic br, input logic b, input logic j, input logic jr,
                        input logic [31:0] im, input logic [31:0] rs,
                        input logic [31:0] tgt, input logic trap);
        {branch_result, is_branch, is_jal, is_jalr} = {br, b, j, jr};
        imm = im;
        rs1_data = rs;
        commit = 1;
        tick();
        commit = 0;
        {branch_result, is_branch, is_jal, is_jalr} = 4'b0;
        if (trap) begin
            exp_trap_pc = cur_pc;
            chk("trap_pulse", misalign_trap, 1);
            chk("trap_pc", trap_pc, exp_trap_pc);
            chk("trap_retired", retired_count, exp_ret);
            tick();
            chk("trap_pulse_end", misalign_trap, 0);
            chk("trap_refetch", imem_req, 1);
            exp_q.push_back(TRAP_VEC);
        end else begin
            exp_ret = exp_ret + 1;
            chk("no_trap", misalign_trap, 0);
            chk("retired", retired_count, exp_ret);
            chk("next_pc", pc, tgt);
            chk("refetch_latency", imem_req, 1);
            exp_q.push_back(tgt);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_trap", misalign_trap, 0);
        chk("rst_pc", pc, 0);
        chk("rst_trap_pc", trap_pc, 0);
        chk("rst_retired", retired_count, 0);
        rst = 0;
        exp_q.push_back(32'h0);
        tick();
        chk("idle_to_fetch", imem_req, 1);
        fetch();
        exec(0, 0, 1, 0, 32'h100, 0, 32'h100, 0);
        fetch();
        exec(1, 1, 0, 0, 32'hFFFF_FFF8, 0, 32'h0F8, 0);
        fetch();
        exec(0, 0, 1, 0, 32'h8, 0, 32'h100, 0);
        fetch();
        exec(0, 1, 0, 0, 32'hFFFF_FFF8, 0, 32'h104, 0);
        fetch();
        exec(0, 0, 0, 1, 32'h4, 32'h2001, 32'h2004, 0);
        fetch();
        exec(0, 0, 0, 1, 32'h0, 32'h2002, 0, 1);
        fetch();
        exec(0, 0, 1, 1, 32'h10, 32'h3000, 32'h3010, 0);
        fetch();
        exec(0, 0, 0, 1, 32'hC, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 0);
        fetch();
        chk("pc_plus4_wrap", pc_plus4, 32'h0);
        exec(0, 0, 0, 0, 32'h40, 0, 32'h0, 0);
        fetch();
        is_jal = 1;
        imm = 32'h40;
        tick();
        tick();
        chk("exec_hold_valid", instr_valid, 1);
        chk("exec_hold_pc", pc, 32'h0);
        exec(0, 0, 1, 0, 32'h6, 0, 0, 1);
        wait_req();
        a = exp_q.pop_front();
        commit = 1;
        is_jal = 1;
        imm = 32'h20;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req", imem_req, 1);
            chk("stall_addr", imem_addr, a);
        end
        commit = 0;
        is_jal = 0;
        chk("trap_pc_hold", trap_pc, exp_trap_pc);
        rst = 1;
        tick();
        rst = 0;
        exp_ret = 0;
        chk("midfetch_rst_req", imem_req, 0);
        chk("midfetch_rst_pc", pc, 0);
        chk("midfetch_rst_retired", retired_count, 0);
        chk("midfetch_rst_trap_pc", trap_pc, 0);
        exp_q.push_back(32'h0);
        fetch();
        force dut.retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count;
        #1;
        chk("preload_retired", retired_count, 32'hFFFF_FFFF);
        exp_ret = 32'hFFFF_FFFF;
        exec(0, 0, 0, 0, 0, 0, 32'h4, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
